wb_stage: RTL

Parametrised writeback stage for the RV32I pipeline, sitting between the MEM stage and the register file. It selects one of `NSRC` result sources and aligns, sign- or zero-extends sub-word load data. The result is held in a MEM/WB pipeline register with stall/flush control, and the stage counts retired instructions. It replaces the fixed 3-input combinational writeback mux with a 1-cycle registered stage.

---
 rtl/wb_pkg.sv | 20 ++
 rtl/ld_formatter.sv | 31 +++
 rtl/wb_stage.sv | 97 +++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// Writeback stage shared types and constants.
// Source indices and load funct3 encodings.
package wb_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    WB_LSU = 2'd0,
    WB_ALU = 2'd1,
    WB_PC4 = 2'd2,
    WB_CSR = 2'd3
  } wb_sel_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/ld_formatter.sv
// Sub-word load alignment and extension.
// Purely combinational; shared with the LSU.
module ld_formatter #(
  parameter int XLEN = wb_pkg::XLEN
) (
  input  logic [XLEN-1:0] word,
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  output logic [XLEN-1:0] result
);
  import wb_pkg::*;

  logic [7:0]  ld_b;
  logic [15:0] ld_h;

  assign ld_b = word[{addr_lo, 3'b000} +: 8];
  assign ld_h = word[{addr_lo[1], 4'b0000} +: 16];

  // Pick the extension for the load type; unknown types pass the word.
  always_comb begin
    result = word;
    unique case (funct3)
      F3_LB:   result = {{(XLEN-8){ld_b[7]}}, ld_b};
      F3_LBU:  result = {{(XLEN-8){1'b0}}, ld_b};
      F3_LH:   result = {{(XLEN-16){ld_h[15]}}, ld_h};
      F3_LHU:  result = {{(XLEN-16){1'b0}}, ld_h};
      default: result = word;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Registered writeback stage: source select,
// MEM/WB register with stall/flush, retire counter.
module wb_stage #(
  parameter int XLEN  = wb_pkg::XLEN,
  parameter int NSRC  = 4,
  parameter int SEL_W = $clog2(NSRC)
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_valid,
  input  logic                 i_stall,
  input  logic                 i_flush,
  input  logic [NSRC*XLEN-1:0] i_src_data,
  input  logic [SEL_W-1:0]     i_wb_sel,
  input  logic [2:0]           i_ld_funct3,
  input  logic [1:0]           i_ld_addr_lo,
  input  logic [4:0]           i_rd_addr,
  input  logic                 i_rd_wren,
  output logic                 o_valid,
  output logic [4:0]           o_rd_addr,
  output logic                 o_rd_wren,
  output logic [XLEN-1:0]      o_wb_data,
  output logic [63:0]          o_instret
);
  import wb_pkg::*;

  logic [XLEN-1:0] ld_word;
  logic [XLEN-1:0] wb_src;
  logic [XLEN-1:0] wb_next;
  logic            wren_next;
  logic            retire;

  logic            valid_q;
  logic [4:0]      rd_q;
  logic            wren_q;
  logic [XLEN-1:0] data_q;
  logic [63:0]     instret_q;

  ld_formatter #(
    .XLEN(XLEN)
  ) u_fmt (
    .word   (i_src_data[XLEN-1:0]),
    .funct3 (i_ld_funct3),
    .addr_lo(i_ld_addr_lo),
    .result (ld_word)
  );

  // Out-of-range selects fall back to the LSU slice.
  always_comb begin
    wb_src = i_src_data[XLEN-1:0];
    for (int k = 1; k < NSRC; k++) begin
      if (i_wb_sel == SEL_W'(k))
        wb_src = i_src_data[k*XLEN +: XLEN];
    end
  end

  assign wb_next   = (i_wb_sel == SEL_W'(WB_LSU))
                   ? ld_word : wb_src;
  assign wren_next = i_valid & i_rd_wren
                   & (i_rd_addr != 5'd0);

  // Occupant leaves unless held; flush beats stall.
  assign retire = valid_q & (i_flush | ~i_stall);

  // MEM/WB register: flush inserts a bubble, stall holds.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q <= 1'b0;
      rd_q    <= '0;
      wren_q  <= 1'b0;
      data_q  <= '0;
    end else if (i_flush) begin
      valid_q <= 1'b0;
      wren_q  <= 1'b0;
    end else if (!i_stall) begin
      valid_q <= i_valid;
      rd_q    <= i_rd_addr;
      wren_q  <= wren_next;
      data_q  <= wb_next;
    end
  end

  // Retired-instruction counter, wraps naturally.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      instret_q <= '0;
    else if (retire)
      instret_q <= instret_q + 64'd1;
  end

  assign o_valid   = valid_q;
  assign o_rd_addr = rd_q;
  assign o_rd_wren = wren_q;
  assign o_wb_data = data_q;
  assign o_instret = instret_q;

endmodule
